// File: rtl/rv32_fetch_align_decoder.sv
// rtl/rv32_fetch_align_decoder.sv - fetch-word realigner, rv32 decoder and output queue
// Splits 32-bit fetch words into 16/32-bit instructions and queues decoded results.
package rv32_fetch_align_pkg;
   typedef struct packed {
      logic        invalid;
      logic        reg_write;
      logic        use_imm;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        is_lui;
      logic        is_auipc;
      logic [3:0]  alu_op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } decoded_instr_t;

   localparam decoded_instr_t NOP_CTRL = '0;
endpackage

module rv32_fetch_align_decoder
   import rv32_fetch_align_pkg::*;
#(
   parameter int ENABLE_C   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           flush,
   input  logic           fetch_valid,
   output logic           fetch_ready,
   input  logic [31:0]    fetch_word,
   input  logic [31:0]    fetch_pc,
   output logic           dec_valid,
   input  logic           dec_ready,
   output logic [31:0]    dec_instr,
   output logic [31:0]    dec_pc,
   output logic           dec_compressed,
   output decoded_instr_t dec_decoded
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      logic           compressed;
      decoded_instr_t decoded;
   } entry_t;

   function automatic decoded_instr_t decode32(input logic [31:0] i);
      decoded_instr_t d;
      logic [31:0] imm_i;
      d = NOP_CTRL;
      imm_i = {{20{i[31]}}, i[31:20]};
      case (i[6:0])
         7'b0110111: begin
            d.reg_write = 1'b1; d.use_imm = 1'b1; d.is_lui = 1'b1;
            d.rd = i[11:7]; d.imm = {i[31:12], 12'h000};
         end
         7'b0010111: begin
            d.reg_write = 1'b1; d.use_imm = 1'b1; d.is_auipc = 1'b1;
            d.rd = i[11:7]; d.imm = {i[31:12], 12'h000};
         end
         7'b1101111: begin
            d.reg_write = 1'b1; d.is_jal = 1'b1; d.rd = i[11:7];
            d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         end
         7'b1100111: begin
            d.reg_write = 1'b1; d.use_imm = 1'b1; d.is_jalr = 1'b1;
            d.rd = i[11:7]; d.rs1 = i[19:15]; d.imm = imm_i;
         end
         7'b1100011: begin
            d.is_branch = 1'b1; d.rs1 = i[19:15]; d.rs2 = i[24:20];
            d.alu_op = {1'b0, i[14:12]};
            d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         end
         7'b0010011: begin
            d.reg_write = 1'b1; d.use_imm = 1'b1; d.rd = i[11:7]; d.rs1 = i[19:15];
            d.alu_op = {(i[14:12] == 3'b101) & i[30], i[14:12]}; d.imm = imm_i;
         end
         7'b0110011: begin
            d.reg_write = 1'b1; d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
            d.alu_op = {i[30], i[14:12]};
         end
         default: d.invalid = 1'b1;
      endcase
      return d;
   endfunction

   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             hold_valid;
   logic [15:0]      hold_half;
   logic [31:0]      hold_pc;
   logic             accept, pop, a_valid, b_valid, hold_load, up_scan, lo_c, hi_c;
   logic             push_first, push_second;
   logic [1:0]       n_push;
   logic [15:0]      lo, hi;
   logic [31:0]      base_pc;
   entry_t           slot_a, slot_b, first;
   logic             unused_bits;

   assign unused_bits = fetch_pc[0];
   assign fetch_ready = (count <= CNT_W'(FIFO_DEPTH - 2)) & ~flush;
   assign accept      = fetch_valid & fetch_ready;
   assign dec_valid   = (count != '0);
   assign pop         = dec_valid & dec_ready;

   always_comb begin
      lo        = fetch_word[15:0];
      hi        = fetch_word[31:16];
      lo_c      = (lo[1:0] != 2'b11);
      hi_c      = (hi[1:0] != 2'b11);
      base_pc   = {fetch_pc[31:2], 2'b00};
      slot_a    = '0;
      slot_b    = '0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      hold_load = 1'b0;
      up_scan   = 1'b0;
      if (ENABLE_C != 0) begin
         // The low slot is the held straddle, or the lower half unless we jumped to the upper one.
         a_valid = hold_valid | ~fetch_pc[1];
         if (hold_valid) begin
            slot_a.instr   = {lo, hold_half};
            slot_a.pc      = hold_pc;
            slot_a.decoded = decode32({lo, hold_half});
         end else if (lo_c) begin
            slot_a.instr      = {16'h0000, lo};
            slot_a.pc         = base_pc;
            slot_a.compressed = 1'b1;
            slot_a.decoded    = NOP_CTRL;
         end else begin
            slot_a.instr   = fetch_word;
            slot_a.pc      = base_pc;
            slot_a.decoded = decode32(fetch_word);
         end
         up_scan           = hold_valid | fetch_pc[1] | lo_c;
         b_valid           = up_scan & hi_c;
         hold_load         = up_scan & ~hi_c;
         slot_b.instr      = {16'h0000, hi};
         slot_b.pc         = {fetch_pc[31:2], 2'b10};
         slot_b.compressed = 1'b1;
         slot_b.decoded    = NOP_CTRL;
      end else begin
         a_valid        = 1'b1;
         slot_a.instr   = fetch_word;
         slot_a.pc      = base_pc;
         slot_a.decoded = decode32(fetch_word);
         if (lo_c | fetch_pc[1]) begin
            slot_a.decoded         = NOP_CTRL;
            slot_a.decoded.invalid = 1'b1;
         end
      end
   end

   assign first       = a_valid ? slot_a : slot_b;
   assign push_first  = accept & (a_valid | b_valid);
   assign push_second = accept & a_valid & b_valid;
   assign n_push      = {1'b0, push_first} + {1'b0, push_second};

   generate
      if (ENABLE_C != 0) begin : g_hold
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               hold_valid <= 1'b0;
               hold_half  <= '0;
               hold_pc    <= '0;
            end else if (flush) begin
               hold_valid <= 1'b0;
            end else if (accept) begin
               hold_valid <= hold_load;
               if (hold_load) begin
                  hold_half <= hi;
                  hold_pc   <= {fetch_pc[31:2], 2'b10};
               end
            end
         end
      end else begin : g_no_hold
         assign hold_valid = 1'b0;
         assign hold_half  = '0;
         assign hold_pc    = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_first)  mem[wr_ptr] <= first;
         if (push_second) mem[wr_ptr + PTR_W'(1)] <= slot_b;
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         count  <= count + CNT_W'(n_push) - CNT_W'(pop);
      end
   end

   assign dec_instr      = mem[rd_ptr].instr;
   assign dec_pc         = mem[rd_ptr].pc;
   assign dec_compressed = mem[rd_ptr].compressed;
   assign dec_decoded    = mem[rd_ptr].decoded;
endmodule

// File: doc/rv32_fetch_align_decoder.md
Name: rv32_fetch_align_decoder

Overview:
- Parametrised decode-stage successor sitting between instruction fetch and the execute issue logic.
- Accepts 32-bit fetch words over a valid/ready handshake and splits them into instruction boundaries.
- When ENABLE_C=1, realigns 16-bit instructions and 32-bit instructions that straddle two words, using a halfword hold register.
- Decodes each instruction into decoded_instr_t and buffers results in a FIFO_DEPTH-entry queue that drives a valid/ready consumer port.

Parameters:
- ENABLE_C, 1: 1 = 16-bit-aligned instruction stream supported; 0 = 32-bit only, and opcode[1:0]!=2'b11 is illegal.
- FIFO_DEPTH, 4: output queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  drops all held and queued state (branch redirect).
- fetch_valid  in  1  fetch_word/fetch_pc are valid.
- fetch_ready  out  1  stage accepts a word this cycle.
- fetch_word  in  32  instruction word; lower halfword is at the lower address.
- fetch_pc  in  32  word address; bit 1 set = start at the upper halfword (jump target); bit 0 is ignored.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  consumer takes the head.
- dec_instr  out  32  raw instruction; compressed instructions are zero-extended from 16 bits.
- dec_pc  out  32  instruction address.
- dec_compressed  out  1  head is a 16-bit instruction.
- dec_decoded  out  decoded_instr_t  decoded control for the head.

Behaviour:
- Reset (async, resetn=0): queue empty, hold register invalid, dec_valid=0, dec_instr=0, dec_pc=0, dec_compressed=0, dec_decoded=NOP control. fetch_ready=1 after reset release.
- Handshakes:
  - A word is accepted when fetch_valid & fetch_ready.
  - fetch_ready = (free queue entries >= 2) & ~flush. The 2 covers the worst case of two instructions per word.
  - A head is dequeued when dec_valid & dec_ready.
  - Enqueue and dequeue may occur in the same cycle.
- Latency: a word accepted in cycle N produces dec_valid=1 in cycle N+1 when the queue was empty. The dec_* outputs come straight from queue storage; there is no combinational path from fetch_* to dec_*.
- Halfword scan of each accepted word, lower half first, where "lower" means the upper half only if fetch_pc[1]=1:
  - Hold valid: emit a 32-bit instruction {fetch_word[15:0], hold_half} at hold_pc, clear hold, then scan the upper half.
  - Scanned half with [1:0]!=2'b11: emit a compressed instruction. Its pc is {fetch_pc[31:2], half_sel, 1'b0}.
  - Lower half with [1:0]==2'b11 and no hold: emit the whole word as a 32-bit instruction at {fetch_pc[31:2], 2'b00}.
  - Upper half with [1:0]==2'b11: store it in hold with hold_pc={fetch_pc[31:2], 2'b10}; nothing is emitted for it this word.
  - A word emits 0, 1 or 2 entries. When two are emitted, the lower-address entry is enqueued first (FIFO order preserved).
- Decode:
  - 32-bit instructions use the standard rv32 decode rules: LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM and OP are decoded; any other opcode sets invalid=1.
  - Compressed instructions get NOP control with invalid=0 and dec_compressed=1; expansion happens downstream.
- ENABLE_C=0:
  - Hold logic is absent.
  - Every accepted word emits exactly one entry at {fetch_pc[31:2], 2'b00}.
  - opcode[1:0]!=2'b11 gives invalid=1 and dec_compressed=0.
  - fetch_pc[1]=1 also gives invalid=1.
- Flush:
  - Takes effect in the same cycle: fetch_ready=0, so no word is accepted.
  - Queue and hold are cleared at the edge, and dec_valid=0 in the next cycle.
  - A dequeue coinciding with flush is still a completed transfer.
- Queue boundaries:
  - Pointer wrap-around uses log2(FIFO_DEPTH)-bit pointers plus an occupancy counter 0..FIFO_DEPTH.
  - With occupancy FIFO_DEPTH-1 and a simultaneous dequeue, fetch_ready is still 0, because it is computed from current occupancy only.
- Reset asserted mid-transfer discards everything; no partial entry survives.

Test Plan:
- Aligned 32-bit stream: words 0x00500093 (addi) and 0x00000037 (lui) at pc 0x0 and 0x4, dec_ready=1 -> two entries on consecutive cycles, pc 0x0 and 0x4, dec_compressed=0, invalid=0, first dec_valid one cycle after acceptance.
- Two compressed in one word, ENABLE_C=1: word 0x00010001 at pc 0x100 -> entries 0x0001@0x100, then 0x0001@0x102, both dec_compressed=1.
- Straddle: word {0x0093, 0x0001}@0x200, then {0x0001, 0x0050}@0x204 -> 0x0001@0x200, 0x00500093@0x202, 0x0001@0x206.
- Jump to halfword: fetch_pc=0x302 with word {0x0001, 0xFFFF} -> only 0x0001@0x302 is emitted; the lower half is ignored.
- Backpressure and flush: dec_ready=0 until the queue holds FIFO_DEPTH-1 entries -> fetch_ready=0. Asserting flush with hold valid -> dec_valid=0 next cycle; a following straddle-free word decodes cleanly.
- ENABLE_C=0 instance: word 0x00000001 -> one entry with invalid=1, dec_compressed=0. Word 0x0000007F (unsupported opcode) -> invalid=1. resetn pulsed mid-stream -> all outputs return to reset values asynchronously.
